// File: rtl/word_port_responder.sv
// word_port_responder
// Responder for dynamically sized bus cycles on the Amiga-side data bus.
// Every accepted cycle gets a programmable number of wait states. It then
// ends as a 16-bit port (DSACK=01), or with a bus error when the register
// index lies outside the implemented register bank. Register data travels on the upper lanes D31:16.
module word_port_responder #(
   parameter int WAIT_STATES = 2,
   parameter int NREGS       = 8
) (
   input  logic        CLK40,
   input  logic        nRESET,
   input  logic        nTS,
   input  logic        nCS,
   input  logic        RnW,
   input  logic [3:0]  A,
   input  logic [1:0]  SIZ,
   input  logic [15:0] D_IN,
   output logic [15:0] D_OUT,
   output logic        D_OE,
   output logic [1:0]  DSACK,
   output logic        nBERR
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_ACK     = 3'd2,
      ST_ERR     = 3'd3,
      ST_RECOVER = 3'd4
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic        rnw_r;
   logic [1:0]  siz_r;
   logic [2:0]  idx_r;
   logic        a0_r;
   logic [15:0] d_out_r;
   logic        d_oe_r;
   logic [1:0]  dsack_r;
   logic        nberr_r;
   logic [15:0] regs_r [0:7];
   logic        rst_sync_r;

   // Byte-lane write mask. Only a byte cycle narrows the write. Long and
   // burst cycles become word accesses because this port ends them as 16-bit.
   function automatic logic [15:0] lane_mask(input logic [1:0] siz, input logic a0);
      logic [15:0] m;
      case (siz)
         2'b01:   m = a0 ? 16'h00FF : 16'hFF00;
         default: m = 16'hFFFF;
      endcase
      return m;
   endfunction

   // Read-back value for an index. Unimplemented indices read as zero.
   function automatic logic [15:0] reg_read(input logic [2:0] idx, input logic [15:0] val);
      logic [15:0] r;
      if (int'(idx) < NREGS) begin
         r = val;
      end else begin
         r = 16'h0000;
      end
      return r;
   endfunction

   // Reset asserts at once and releases on the first clock edge. The FSM can
   // then accept a cycle on the second rising edge after nRESET deasserts.
   always_ff @(posedge CLK40 or negedge nRESET) begin
      if (!nRESET) begin
         rst_sync_r <= 1'b0;
      end else begin
         rst_sync_r <= 1'b1;
      end
   end

   // Cycle FSM. Outputs are registered here together with the transition
   // into the state that drives them.
   always_ff @(posedge CLK40 or negedge rst_sync_r) begin
      if (!rst_sync_r) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         rnw_r   <= 1'b0;
         siz_r   <= 2'b00;
         idx_r   <= 3'd0;
         a0_r    <= 1'b0;
         d_out_r <= 16'h0000;
         d_oe_r  <= 1'b0;
         dsack_r <= 2'b11;
         nberr_r <= 1'b1;
         for (int i = 0; i < 8; i++) begin
            regs_r[i] <= 16'h0000;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!nTS && !nCS) begin
                  rnw_r   <= RnW;
                  siz_r   <= SIZ;
                  idx_r   <= A[3:1];
                  a0_r    <= A[0];
                  d_out_r <= reg_read(A[3:1], regs_r[A[3:1]]);
                  d_oe_r  <= RnW;
                  cnt_r   <= WAIT_LOAD;
                  state_r <= ST_WAIT;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (cnt_r == 4'd0) begin
                  if (int'(idx_r) >= NREGS) begin
                     nberr_r <= 1'b0;
                     d_oe_r  <= 1'b0;
                     state_r <= ST_ERR;
                  end else begin
                     dsack_r <= 2'b01;
                     state_r <= ST_ACK;
                  end
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            ST_ACK: begin
               dsack_r <= 2'b11;
               d_oe_r  <= 1'b0;
               if (!rnw_r) begin
                  regs_r[idx_r] <= (regs_r[idx_r] & ~lane_mask(siz_r, a0_r))
                                 | (D_IN & lane_mask(siz_r, a0_r));
               end else begin
                  regs_r[idx_r] <= regs_r[idx_r];
               end
               state_r <= ST_RECOVER;
            end
            ST_ERR: begin
               nberr_r <= 1'b1;
               state_r <= ST_RECOVER;
            end
            ST_RECOVER: begin
               state_r <= ST_IDLE;
            end
            default: begin
               dsack_r <= 2'b11;
               nberr_r <= 1'b1;
               d_oe_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign D_OUT = d_out_r;
   assign D_OE  = d_oe_r;
   assign DSACK = dsack_r;
   assign nBERR = nberr_r;

endmodule
